// File: rtl/cpu_regfile_mp.sv
// Multi-port register file for the 8-bit CPU datapath: one write port, NUM_RD read ports,
// and an in-place increment/decrement port for pointer registers.
module cpu_regfile_mp #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned REG_RD   = 0,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     idu_en,
    input  logic                     idu_dec,
    input  logic [ADDR_W-1:0]        idu_sel,
    input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
    input  logic [NUM_RD-1:0]        rd_oe,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     idu_wrap,
    output logic                     idu_zero,
    output logic [DATA_W-1:0]        rega,
    output logic [DATA_W-1:0]        regb
);

    logic [DATA_W-1:0]        regs_q [NUM_REGS];
    logic [DATA_W-1:0]        idu_cur;
    logic [DATA_W-1:0]        idu_res;
    logic                     idu_wrap_d, idu_zero_d;
    logic                     idu_wrap_q, idu_zero_q;
    logic                     idu_ok;
    logic [ADDR_W-1:0]        rd_sel_k;
    logic [DATA_W-1:0]        rd_val_k;
    logic [NUM_RD*DATA_W-1:0] rd_comb;

    assign idu_ok = 32'(idu_sel) < NUM_REGS;

    // Flags follow the computed result even when a colliding write discards it.
    always_comb begin
        idu_cur = '0;
        if (idu_ok) begin
            idu_cur = regs_q[idu_sel];
        end
        idu_res    = idu_dec ? idu_cur - DATA_W'(1) : idu_cur + DATA_W'(1);
        idu_wrap_d = idu_dec ? (idu_cur == '0) : (idu_cur == '1);
        idu_zero_d = (idu_res == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            idu_wrap_q <= 1'b0;
            idu_zero_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_en && wr_sel == ADDR_W'(i)) begin
                    regs_q[i] <= wr_data;
                end else if (idu_en && idu_sel == ADDR_W'(i)) begin
                    regs_q[i] <= idu_res;
                end
            end
            if (idu_en) begin
                idu_wrap_q <= idu_wrap_d;
                idu_zero_q <= idu_zero_d;
            end
        end
    end

    // Out-of-range selects read as zero and are never forwarded.
    always_comb begin
        rd_comb  = '0;
        rd_sel_k = '0;
        rd_val_k = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_sel_k = rd_sel[k*ADDR_W +: ADDR_W];
            rd_val_k = '0;
            if (32'(rd_sel_k) < NUM_REGS) begin
                rd_val_k = regs_q[rd_sel_k];
                if (BYPASS != 0) begin
                    if (wr_en && wr_sel == rd_sel_k) begin
                        rd_val_k = wr_data;
                    end else if (idu_en && idu_sel == rd_sel_k) begin
                        rd_val_k = idu_res;
                    end
                end
            end
            if (rd_oe[k]) begin
                rd_comb[k*DATA_W +: DATA_W] = rd_val_k;
            end
        end
    end

    if (REG_RD != 0) begin : g_reg_rd
        logic [NUM_RD*DATA_W-1:0] rd_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_comb;
            end
        end
        assign rd_data = rd_q;
    end else begin : g_comb_rd
        assign rd_data = rd_comb;
    end

    assign idu_wrap = idu_wrap_q;
    assign idu_zero = idu_zero_q;
    assign rega     = regs_q[0];
    assign regb     = regs_q[1];

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// Directed bench for cpu_regfile_mp: four instances (default, no bypass, registered read,
// six-register) share one stimulus stream.
module tb_cpu_regfile_mp;

    logic       clk = 1'b0;
    logic       reset, wr_en, idu_en, idu_dec;
    logic [2:0] wr_sel, idu_sel;
    logic [7:0] wr_data;
    logic [5:0] rd_sel;
    logic [1:0] rd_oe;

    logic [15:0] a_rd, b_rd, r_rd, n_rd;
    logic        a_wrap, a_zero, b_wrap, b_zero, r_wrap, r_zero, n_wrap, n_zero;
    logic [7:0]  a_rega, a_regb, b_rega, b_regb, r_rega, r_regb, n_rega, n_regb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_regfile_mp u_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .idu_en(idu_en), .idu_dec(idu_dec), .idu_sel(idu_sel), .rd_sel(rd_sel),
        .rd_oe(rd_oe), .rd_data(a_rd), .idu_wrap(a_wrap), .idu_zero(a_zero),
        .rega(a_rega), .regb(a_regb)
    );

    cpu_regfile_mp #(.BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .idu_en(idu_en), .idu_dec(idu_dec), .idu_sel(idu_sel), .rd_sel(rd_sel),
        .rd_oe(rd_oe), .rd_data(b_rd), .idu_wrap(b_wrap), .idu_zero(b_zero),
        .rega(b_rega), .regb(b_regb)
    );

    cpu_regfile_mp #(.REG_RD(1)) u_r (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .idu_en(idu_en), .idu_dec(idu_dec), .idu_sel(idu_sel), .rd_sel(rd_sel),
        .rd_oe(rd_oe), .rd_data(r_rd), .idu_wrap(r_wrap), .idu_zero(r_zero),
        .rega(r_rega), .regb(r_regb)
    );

    cpu_regfile_mp #(.NUM_REGS(6)) u_n (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .idu_en(idu_en), .idu_dec(idu_dec), .idu_sel(idu_sel), .rd_sel(rd_sel),
        .rd_oe(rd_oe), .rd_data(n_rd), .idu_wrap(n_wrap), .idu_zero(n_zero),
        .rega(n_rega), .regb(n_regb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [2:0] s0, input logic [2:0] s1);
        rd_sel = {s1, s0};
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    logic [7:0] n_exp [6];

    initial begin
        n_exp = '{8'h00, 8'hC3, 8'h7E, 8'hA5, 8'h77, 8'h3C};

        // Reset overrides a simultaneous write and inc/dec.
        reset = 1'b1; wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'h55;
        idu_en = 1'b1; idu_dec = 1'b0; idu_sel = 3'd1;
        rd_sel = 6'd0; rd_oe = 2'b11;
        tick();
        reset = 1'b0; wr_en = 1'b0; idu_en = 1'b0;
        chk("rst_regrd_out", 32'(r_rd), 32'h0);
        #1;
        chk("rst_rega", 32'(a_rega), 32'h00);
        chk("rst_regb", 32'(a_regb), 32'h00);
        chk("rst_wrap", 32'(a_wrap), 32'h0);
        chk("rst_zero", 32'(a_zero), 32'h0);
        for (int i = 0; i < 8; i++) begin
            set_rd(3'(i), 3'd0);
            #1;
            chk($sformatf("rst_reg%0d", i), 32'(a_rd[7:0]), 32'h00);
        end

        // Basic writes and two-port read.
        wr(3'd3, 8'hA5);
        wr(3'd5, 8'h3C);
        set_rd(3'd3, 3'd5);
        #1;
        chk("basic_p0", 32'(a_rd[7:0]), 32'hA5);
        chk("basic_p1", 32'(a_rd[15:8]), 32'h3C);
        chk("basic_nobyp_p0", 32'(b_rd[7:0]), 32'hA5);

        // Same-cycle write forwarding versus stored-only read.
        wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h7E;
        set_rd(3'd2, 3'd5);
        #1;
        chk("byp_same_cycle", 32'(a_rd[7:0]), 32'h7E);
        chk("nobyp_same_cycle", 32'(b_rd[7:0]), 32'h00);
        tick();
        wr_en = 1'b0;
        #1;
        chk("nobyp_next_cycle", 32'(b_rd[7:0]), 32'h7E);
        chk("regrd_byp_sampled", 32'(r_rd[7:0]), 32'h7E);

        // Increment / decrement with wrap and zero.
        wr(3'd7, 8'hFF);
        idu_en = 1'b1; idu_dec = 1'b0; idu_sel = 3'd7;
        set_rd(3'd7, 3'd5);
        tick();
        idu_en = 1'b0;
        #1;
        chk("inc_ff_val", 32'(a_rd[7:0]), 32'h00);
        chk("inc_ff_wrap", 32'(a_wrap), 32'h1);
        chk("inc_ff_zero", 32'(a_zero), 32'h1);
        idu_en = 1'b1; idu_dec = 1'b1;
        tick();
        idu_en = 1'b0;
        #1;
        chk("dec_00_val", 32'(a_rd[7:0]), 32'hFF);
        chk("dec_00_wrap", 32'(a_wrap), 32'h1);
        chk("dec_00_zero", 32'(a_zero), 32'h0);
        tick();
        chk("flag_hold_wrap", 32'(a_wrap), 32'h1);
        wr(3'd7, 8'h10);
        idu_en = 1'b1; idu_dec = 1'b1;
        #1;
        chk("dec_byp", 32'(a_rd[7:0]), 32'h0F);
        tick();
        idu_en = 1'b0;
        #1;
        chk("dec_10_val", 32'(a_rd[7:0]), 32'h0F);
        chk("dec_10_wrap", 32'(a_wrap), 32'h0);
        chk("dec_10_zero", 32'(a_zero), 32'h0);

        // Collision: write wins, flags still come from the discarded inc.
        wr(3'd4, 8'hFF);
        wr(3'd6, 8'h01);
        wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h99;
        idu_en = 1'b1; idu_dec = 1'b0; idu_sel = 3'd4;
        set_rd(3'd4, 3'd6);
        #1;
        chk("coll_byp_prio", 32'(a_rd[7:0]), 32'h99);
        tick();
        wr_en = 1'b0; idu_en = 1'b0;
        #1;
        chk("coll_val", 32'(a_rd[7:0]), 32'h99);
        chk("coll_wrap", 32'(a_wrap), 32'h1);
        chk("coll_zero", 32'(a_zero), 32'h1);
        wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h77;
        idu_en = 1'b1; idu_dec = 1'b0; idu_sel = 3'd6;
        tick();
        wr_en = 1'b0; idu_en = 1'b0;
        #1;
        chk("dual_wr_val", 32'(a_rd[7:0]), 32'h77);
        chk("dual_inc_val", 32'(a_rd[15:8]), 32'h02);
        chk("dual_wrap", 32'(a_wrap), 32'h0);

        // Registered read and output enable.
        wr(3'd1, 8'hC3);
        set_rd(3'd0, 3'd1);
        rd_oe = 2'b11;
        tick();
        chk("regrd_p1", 32'(r_rd[15:8]), 32'hC3);
        rd_oe = 2'b01;
        #1;
        chk("comb_oe_off", 32'(a_rd[15:8]), 32'h00);
        chk("regrd_hold", 32'(r_rd[15:8]), 32'hC3);
        tick();
        chk("regrd_oe_off", 32'(r_rd[15:8]), 32'h00);
        chk("regb_view", 32'(a_regb), 32'hC3);
        rd_oe = 2'b11;
        wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h11;
        #1;
        chk("regb_no_byp", 32'(a_regb), 32'hC3);
        chk("p1_byp", 32'(a_rd[15:8]), 32'h11);
        wr_en = 1'b0;

        // Six-register instance: out-of-range selects.
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 8'hEE;
        set_rd(3'd7, 3'd6);
        #1;
        chk("oor_byp_p0", 32'(n_rd[7:0]), 32'h00);
        chk("oor_p1", 32'(n_rd[15:8]), 32'h00);
        tick();
        wr_en = 1'b0;
        #1;
        chk("oor_rd7", 32'(n_rd[7:0]), 32'h00);
        for (int i = 0; i < 6; i++) begin
            set_rd(3'(i), 3'd0);
            #1;
            chk($sformatf("oor_keep%0d", i), 32'(n_rd[7:0]), 32'(n_exp[i]));
        end

        // Reset mid-sequence with inc/dec active.
        idu_en = 1'b1; idu_dec = 1'b1; idu_sel = 3'd0;
        tick();
        idu_en = 1'b0;
        chk("pre_rst_wrap", 32'(a_wrap), 32'h1);
        chk("pre_rst_rega", 32'(a_rega), 32'hFF);
        reset = 1'b1; idu_en = 1'b1; idu_dec = 1'b0; idu_sel = 3'd3;
        tick();
        reset = 1'b0; idu_en = 1'b0;
        chk("mid_rst_regrd", 32'(r_rd), 32'h0);
        #1;
        chk("mid_rst_wrap", 32'(a_wrap), 32'h0);
        chk("mid_rst_zero", 32'(a_zero), 32'h0);
        chk("mid_rst_rega", 32'(a_rega), 32'h00);
        for (int i = 0; i < 8; i++) begin
            set_rd(3'(i), 3'(i % 6));
            #1;
            chk($sformatf("mid_rst_a%0d", i), 32'(a_rd[7:0]), 32'h00);
            chk($sformatf("mid_rst_n%0d", i), 32'(n_rd[15:8]), 32'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_regfile_mp.md
Name: cpu_regfile_mp

Overview:
- Parametrised multi-port register file for the 8-bit CPU datapath; successor to the single-read-port register file.
- Provides one bus write port and NUM_RD independent read ports, with optional write-through bypass and optional registered reads.
- Adds an in-place increment/decrement port for pointer registers (SP, index), with wrap and zero status, so the controller updates pointers without an ALU pass.
- Sits between the shared bus, the ALU operand inputs and the control FSM.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 8, number of registers; must be at least 2.
- ADDR_W, $clog2(NUM_REGS), select width.
- NUM_RD, 2, number of read ports, 1..4.
- REG_RD, 0, 0 = combinational read; 1 = read data registered (1-cycle latency).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high; clears all state on the next clk.
- wr_en  in  1  write-port enable.
- wr_sel  in  ADDR_W  write-port register select.
- wr_data  in  DATA_W  write-port data (from bus).
- idu_en  in  1  increment/decrement enable.
- idu_dec  in  1  0 = +1, 1 = -1.
- idu_sel  in  ADDR_W  register updated by the inc/dec port.
- rd_sel  in  NUM_RD*ADDR_W  packed read selects; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_oe  in  NUM_RD  per-port output enable.
- rd_data  out  NUM_RD*DATA_W  packed read data.
- idu_wrap  out  1  registered; the last inc/dec wrapped (0xFF->0x00 or 0x00->0xFF at DATA_W).
- idu_zero  out  1  registered; the last inc/dec result was zero.
- rega  out  DATA_W  live view of R0.
- regb  out  DATA_W  live view of R1.

Behaviour:
- Reset:
  - All registers are 0.
  - idu_wrap and idu_zero are 0.
  - REG_RD=1 read pipeline registers are 0, so rd_data = 0 in the cycle after reset.
  - Reset overrides wr_en and idu_en in the same cycle.
- Write port: on posedge with wr_en=1, R[wr_sel] <= wr_data.
- Inc/dec port:
  - On posedge with idu_en=1, R[idu_sel] <= R[idu_sel] ± 1, modulo 2^DATA_W.
  - idu_wrap and idu_zero update on the same edge and hold their value while idu_en=0.
- Collision (wr_en=1, idu_en=1, wr_sel==idu_sel):
  - The write port wins; the inc/dec result is discarded.
  - idu_wrap and idu_zero still update from the computed (discarded) result.
- Different targets: both updates happen on the same edge.
- Out-of-range selects (NUM_REGS not a power of 2):
  - Write and inc/dec to an index >= NUM_REGS are ignored.
  - A read of an index >= NUM_REGS returns 0.
- Read port k, REG_RD=0:
  - rd_data[k] = rd_oe[k] ? value(rd_sel[k]) : 0, combinational.
  - No tri-states.
- Read port k, REG_RD=1:
  - The same expression is sampled at posedge and presented for the following cycle.
  - rd_oe is sampled with it.
- value(s) with BYPASS=1:
  - If wr_en and wr_sel==s: wr_data.
  - Else if idu_en and idu_sel==s: the inc/dec result.
  - Else R[s].
  - Write has priority, consistent with the collision rule.
- value(s) with BYPASS=0: always R[s] as stored before the edge.
- rega and regb show stored contents only; they are never bypassed.
- Latency summary:
  - Write-to-read-visible: 0 cycles with BYPASS=1; 1 cycle with BYPASS=0 (combinational read).
  - Add 1 cycle when REG_RD=1.
- Any number of read ports may select the same register simultaneously.

Test Plan:
- Reset/basic: assert reset for 1 cycle with wr_en=1, wr_data=0x55 -> all registers read 0x00 and idu_wrap=idu_zero=0. Then write R3=0xA5, R5=0x3C; read port 0 sel 3, port 1 sel 5 -> 0xA5 and 0x3C.
- Bypass (BYPASS=1, REG_RD=0): wr_en=1, wr_sel=2, wr_data=0x7E with rd_sel[0]=2 in the same cycle -> rd_data[0]=0x7E in that cycle. With BYPASS=0 -> the old value in that cycle, 0x7E in the next.
- Inc/dec wrap:
  - R7=0xFF, idu_en=1, idu_dec=0, idu_sel=7 -> R7=0x00, idu_wrap=1, idu_zero=1.
  - Then dec -> R7=0xFF, idu_wrap=1, idu_zero=0.
  - Then R7=0x10 dec -> 0x0F, idu_wrap=0, idu_zero=0.
- Collision: R4=0x10; wr_en=1 sel 4 data 0x99 and idu_en=1 inc sel 4 -> R4=0x99. Same cycle with idu_sel=6 where R6=0x01 -> R4=0x99 and R6=0x02.
- Output enable / registered read (REG_RD=1): R1=0xC3, rd_sel[1]=1, rd_oe[1]=1 at edge N -> rd_data[1]=0xC3 from edge N. With rd_oe[1]=0 at edge N+1 -> 0x00 from edge N+1.
- Non-power-of-2 depth (NUM_REGS=6): write sel 7 data 0xEE -> no register changes, and a read of sel 7 returns 0x00. Reset asserted mid-sequence with idu_en=1 -> all registers clear and flags go to 0.
